// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with tear-free double-buffered update.
// Optional macro SEG7_LZ_SUPPRESS_EN blanks leading-zero digits.
module seg7_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tc;
    logic                  wrap;

    logic                  pending;
    logic [4*DIGITS-1:0]   sh_val;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_bl;
    logic [4*DIGITS-1:0]   ds_val;
    logic [DIGITS-1:0]     ds_dp;
    logic [DIGITS-1:0]     ds_bl;

    logic [3:0]            nib;
    logic                  cur_dp;
    logic                  cur_bl;
    logic                  sup;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     an_nx;
    logic [7:0]            seg_nx;
    logic                  fs_nx;

    assign tc   = (cnt == CW'(SCAN_DIV - 1));
    assign wrap = tc && (idx == IW'(DIGITS - 1));

    // Prescaler and digit index advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow capture and frame-boundary transfer to the display set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            sh_val  <= '0;
            sh_dp   <= '0;
            sh_bl   <= '0;
            ds_val  <= '0;
            ds_dp   <= '0;
            ds_bl   <= '0;
        end else begin
            if (load) begin
                sh_val <= value;
                sh_dp  <= dp_mask;
                sh_bl  <= blank_mask;
            end
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    ds_val <= value;
                    ds_dp  <= dp_mask;
                    ds_bl  <= blank_mask;
                end else if (pending) begin
                    ds_val <= sh_val;
                    ds_dp  <= sh_dp;
                    ds_bl  <= sh_bl;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select current digit data and build the next output pattern
    always_comb begin
        nib    = 4'h0;
        cur_dp = 1'b0;
        cur_bl = 1'b0;
        an_nx  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib      = ds_val[4*i +: 4];
                cur_dp   = ds_dp[i];
                cur_bl   = ds_bl[i];
                an_nx[i] = 1'b0;
            end
        end
`ifdef SEG7_LZ_SUPPRESS_EN
        begin
            logic [IW-1:0] msd;
            msd = '0;
            for (int i = 1; i < DIGITS; i++) begin
                if (ds_val[4*i +: 4] != 4'h0) begin
                    msd = IW'(i);
                end
            end
            sup = (idx > msd);
        end
`else
        sup = 1'b0;
`endif
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h18;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
        if (cur_bl || sup) begin
            seg_nx = 8'hFF;
        end else begin
            seg_nx = {~cur_dp, glyph};
        end
        fs_nx = (cnt == '0) && (idx == '0);
    end

    // Registered digit enables, segments and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nx;
            seg         <= seg_nx;
            frame_start <= fs_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver, DIGITS=4, SCAN_DIV=4.
// Vectors table plus hand sequences for update timing and reset.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    int pass_cnt = 0;
    int total    = 0;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     v;
        logic [3:0]      dp;
        logic [3:0]      bl;
        logic [3:0][7:0] e;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic wait_fs(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 40);
        chk({nm, " fs"}, {7'h0, frame_start}, 8'h01);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] bl);
        value      = v;
        dp_mask    = dp;
        blank_mask = bl;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic check_frame(input string nm, input logic [3:0][7:0] e);
        logic [3:0] a;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            a = ~(4'b0001 << k);
            chk($sformatf("%s an d%0d", nm, k), {4'h0, an}, {4'h0, a});
            chk($sformatf("%s seg d%0d", nm, k), seg, e[k]);
        end
    endtask

    initial begin
        logic [3:0][7:0] rst_exp;
        logic [3:0][7:0] all2;
        int n;
`ifdef SEG7_LZ_SUPPRESS_EN
        rst_exp = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
        vecs[1] = '{16'h00A0, 4'b0010, 4'b0000,
                    {8'hFF, 8'hFF, 8'h08, 8'hC0}};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000,
                    {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
`else
        rst_exp = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
        vecs[1] = '{16'h00A0, 4'b0010, 4'b0000,
                    {8'hC0, 8'hC0, 8'h08, 8'hC0}};
        vecs[3] = '{16'h0000, 4'b0000, 4'b0000,
                    {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
`endif
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000,
                    {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[2] = '{16'h5678, 4'b0100, 4'b0100,
                    {8'h92, 8'hFF, 8'hF8, 8'h80}};
        vecs[4] = '{16'hFFFF, 4'b1111, 4'b0000,
                    {8'h0E, 8'h0E, 8'h0E, 8'h0E}};
        all2 = {8'hA4, 8'hA4, 8'hA4, 8'hA4};

        rst_n      = 1'b0;
        load       = 1'b0;
        value      = '0;
        dp_mask    = '0;
        blank_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst an", {4'h0, an}, 8'h0F);
        chk("rst seg", seg, 8'hFF);
        chk("rst fs", {7'h0, frame_start}, 8'h00);
        rst_n = 1'b1;
        wait_fs("boot");
        check_frame("boot", rst_exp);

        for (int i = 0; i < 5; i++) begin
            wait_fs($sformatf("v%0d pre", i));
            do_load(vecs[i].v, vecs[i].dp, vecs[i].bl);
            wait_fs($sformatf("v%0d", i));
            check_frame($sformatf("v%0d", i), vecs[i].e);
        end

        wait_fs("tear pre");
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        chk("tear an d2", {4'h0, an}, 8'h0B);
        chk("tear seg d2", seg, 8'h0E);
        repeat (4) @(negedge clk);
        chk("tear seg d3", seg, 8'h0E);
        wait_fs("tear");
        check_frame("tear", all2);

        wait_fs("wrapld pre");
        do_load(16'h3333, 4'b0000, 4'b0000);
        repeat (13) @(negedge clk);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("wrapld fs", {7'h0, frame_start}, 8'h01);
        chk("wrapld an", {4'h0, an}, 8'h0E);
        chk("wrapld seg", seg, 8'h8E);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 40);
        chk("fs period", n[7:0], 8'd16);
        chk("wrapld seg next", seg, 8'h8E);

        wait_fs("rst pre");
        do_load(16'h7777, 4'b0000, 4'b0000);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst an", {4'h0, an}, 8'h0F);
        chk("arst seg", seg, 8'hFF);
        chk("arst fs", {7'h0, frame_start}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs("post rst");
        check_frame("post rst", rst_exp);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
